// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: computes a - b - bin with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full_subtractor cell processes the operands
// LSB-first over W cycles, producing a - b - bin with borrow and overflow.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
    logic          borrow;
    logic          ovf_r;
    logic          cell_diff;
    logic          cell_bout;
    logic          accept;
    logic          last_bit;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == LAST);

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // On the final bit the operand registers hold the original sign bits in
    // bit 0, so overflow is derived from the cell inputs and its difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res    <= {cell_diff, res[W-1:1]};
            borrow <= cell_bout;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                ovf_r <= (a_sh[0] != b_sh[0]) && (cell_diff != a_sh[0]);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign diff = res;
    assign bout = borrow;
    assign ovf  = ovf_r;

endmodule
